shift_sequencer: RTL

Sequential front-end controller that sits directly upstream of the 8-bit combinational barrel shifter, which takes 3-bit shift amounts. It accepts shift requests of 0–31 positions over a valid/ready handshake. Each request is split into passes of at most 7 positions. The shifter is driven once per cycle, its result is fed back, and the final value is held for a downstream consumer with backpressure. This extends the shifter's range to 31 positions without widening its datapath.

---
 rtl/shift_sequencer.sv | 96 +++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// Iterative front-end for an 8-bit, 3-bit-amount barrel shifter: splits 0..31 shifts into passes of <=7.
// Optional SHIFT_SEQ_SATURATE_EN short-circuits amounts >= 8 straight to a zero result.
module shift_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [4:0] in_amt,
  input  logic       in_dir,
  output logic [7:0] sh_inp,
  output logic [2:0] sh_shamt,
  output logic       sh_dir,
  input  logic [7:0] sh_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_zero,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [4:0] rem_q, rem_d;
  logic       dir_q, dir_d;
  logic [2:0] step;
  logic [4:0] rem_left;

  function automatic logic [2:0] pass_step(input logic [4:0] rem);
    return (rem > 5'd7) ? 3'd7 : rem[2:0];
  endfunction

  assign step     = pass_step(rem_q);
  assign rem_left = rem_q - {2'b00, step};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= 8'h00;
      rem_q   <= 5'd0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          rem_d   = in_amt;
          dir_d   = in_dir;
          state_d = (in_amt != 5'd0) ? SHIFT : DONE;
`ifdef SHIFT_SEQ_SATURATE_EN
          if (in_amt >= 5'd8) begin
            data_d  = 8'h00;
            rem_d   = 5'd0;
            state_d = DONE;
          end
`endif
        end
      end
      SHIFT: begin
        // Shifter output is folded back each cycle until the remaining amount is spent.
        data_d = sh_out;
        rem_d  = rem_left;
        if (rem_left == 5'd0) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift amount is forced to zero outside SHIFT so the shifter is a pass-through.
  assign sh_inp    = data_q;
  assign sh_shamt  = (state_q == SHIFT) ? step : 3'd0;
  assign sh_dir    = dir_q;
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;
  assign out_zero  = (data_q == 8'h00);
  assign busy      = (state_q != IDLE);

endmodule
